hash_result_scan: RTL and testbench

Post-processing reader for the nonce-search hash engine. After the hash engine writes one 32-bit H0 word per nonce into shared memory, this block reads those words back over the same synchronous memory port. It picks the nonce with the smallest hash, tests that hash against a difficulty target, and writes a two-word result record back to memory. It sits beside the hash engine on the shared memory bus and is started by the top-level controller after the hash engine reports done.

---
 rtl/hash_result_scan_if.sv | 35 +++
 rtl/hash_result_scan.sv | 174 +++++++++++++++++
 tb/tb_hash_result_scan.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hash_result_scan_if.sv
// Shared memory port between the result scanner and the synchronous RAM.
// Latency: none; this only bundles wires.
// Backpressure: none; the RAM accepts one access per mem_clk edge.
//
// Signals:
//   mem_clk        clock the RAM registers its address/write on
//   mem_we         write enable
//   mem_addr       word address
//   mem_write_data write data
//   mem_read_data  read data, valid one mem_clk edge after the address is taken
interface hash_result_scan_if;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  // Scanner side drives the address/write phase and samples read data.
  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  // RAM side.
  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/hash_result_scan.sv
// Scans NUM_NONCES hash words, keeps the smallest, writes a 2-word result record.
// Latency: done rises NUM_NONCES+5 edges after the start edge (21 for 16 nonces).
// Backpressure: none; the RAM is assumed to accept one access per cycle.
//
// Ports:
//   clk, reset_n     clock and asynchronous active-low reset
//   start            begin a scan (only looked at while idle)
//   input_addr       address of the hash word for nonce 0
//   result_addr      base address of the record {found,23'b0,nonce} / best_hash
//   target           unsigned difficulty threshold
//   done             high while idle after a completed (or reset) scan
//   found            best_hash < target
//   best_nonce       index of the minimum hash word
//   best_hash        minimum hash word seen
//   mem              shared memory port (master side)
module hash_result_scan #(
  parameter int NUM_NONCES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            input_addr,
  input  logic [15:0]            result_addr,
  input  logic [31:0]            target,
  output logic                   done,
  output logic                   found,
  output logic [7:0]             best_nonce,
  output logic [31:0]            best_hash,
  hash_result_scan_if.master     mem
);

  // Counters need to hold the value NUM_NONCES itself (up to 256).
  localparam logic [8:0] NUM_C  = 9'(NUM_NONCES);
  localparam logic [8:0] LAST_C = 9'(NUM_NONCES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WR0  = 2'd2,
    WR1  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  issue_q, issue_d;
  logic [8:0]  cap_q, cap_d;
  // addr_vld_q: an address was registered at the last edge.
  // rd_vld_q:   the RAM latched that address at the last edge, so its data
  //             is on mem_read_data now and is captured at the coming edge.
  logic        addr_vld_q, addr_vld_d;
  logic        rd_vld_q, rd_vld_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        found_q, found_d;
  logic [7:0]  nonce_q, nonce_d;
  logic [31:0] hash_q, hash_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      issue_q    <= '0;
      cap_q      <= '0;
      addr_vld_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      found_q    <= 1'b0;
      nonce_q    <= '0;
      hash_q     <= 32'hFFFF_FFFF;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      cap_q      <= cap_d;
      addr_vld_q <= addr_vld_d;
      rd_vld_q   <= rd_vld_d;
      done_q     <= done_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      found_q    <= found_d;
      nonce_q    <= nonce_d;
      hash_q     <= hash_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    issue_d    = issue_q;
    cap_d      = cap_q;
    addr_vld_d = 1'b0;
    rd_vld_d   = addr_vld_q;
    done_d     = done_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    found_d    = found_q;
    nonce_d    = nonce_q;
    hash_d     = hash_q;

    unique case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (start) begin
          done_d     = 1'b0;
          addr_d     = input_addr;
          addr_vld_d = 1'b1;
          rd_vld_d   = 1'b0;
          issue_d    = 9'd1;
          cap_d      = 9'd0;
          hash_d     = 32'hFFFF_FFFF;
          nonce_d    = 8'd0;
          found_d    = 1'b0;
          state_d    = READ;
        end else if (!we_q) begin
          // The edge that drops the record write strobe keeps done low, so
          // done only rises once the bus is quiet again.
          done_d = 1'b1;
        end
      end

      READ: begin
        if (issue_q < NUM_C) begin
          addr_d     = input_addr + {7'd0, issue_q};
          addr_vld_d = 1'b1;
          issue_d    = issue_q + 9'd1;
        end
        if (rd_vld_q) begin
          // Strict compare: on a tie the earlier (lower) nonce is kept.
          if (mem.mem_read_data < hash_q) begin
            hash_d  = mem.mem_read_data;
            nonce_d = cap_q[7:0];
            found_d = (mem.mem_read_data < target);
          end
          cap_d = cap_q + 9'd1;
          if (cap_q == LAST_C) begin
            state_d = WR0;
          end
        end
      end

      WR0: begin
        we_d    = 1'b1;
        addr_d  = result_addr;
        wdata_d = {found_q, 23'd0, nonce_q};
        state_d = WR1;
      end

      WR1: begin
        we_d    = 1'b1;
        addr_d  = result_addr + 16'd1;
        wdata_d = hash_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem.mem_clk        = clk;
  assign mem.mem_we         = we_q;
  assign mem.mem_addr       = addr_q;
  assign mem.mem_write_data = wdata_q;

  assign done       = done_q;
  assign found      = found_q;
  assign best_nonce = nonce_q;
  assign best_hash  = hash_q;

endmodule

// File: tb/tb_hash_result_scan.sv
module tb_hash_result_scan;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] input_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash;

  always #5 clk = ~clk;

  hash_result_scan_if bus ();

  hash_result_scan #(.NUM_NONCES(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .input_addr  (input_addr),
    .result_addr (result_addr),
    .target      (target),
    .done        (done),
    .found       (found),
    .best_nonce  (best_nonce),
    .best_hash   (best_hash),
    .mem         (bus)
  );

  // Synchronous RAM: address taken on mem_clk, read data out after that edge.
  // A side load port preloads words while the scanner is idle.
  logic [31:0] mem [0:65535];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  int          wr_cnt = 0;

  always @(posedge bus.mem_clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    bus.mem_read_data <= mem[bus.mem_addr];
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic ld(input logic [15:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  // Starts a scan, checks the address sequence, write strobe timing, the
  // done edge and the number of memory writes. Optionally re-pulses start
  // during READ and WR0.
  task automatic run_scan(input string nm, input logic [15:0] ia, input logic [15:0] ra,
                          input logic [31:0] tg, input bit pulse);
    int          dcyc;
    int          base;
    logic [15:0] ea;
    base        = wr_cnt;
    input_addr  = ia;
    result_addr = ra;
    target      = tg;
    start       = 1'b1;
    @(posedge clk);                       // e0
    #1;
    start = 1'b0;
    chk({nm, "_addr0"}, {16'd0, bus.mem_addr}, {16'd0, ia});
    dcyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k < N) begin
        ea = ia + 16'(k);
        chk($sformatf("%s_addr%0d", nm, k), {16'd0, bus.mem_addr}, {16'd0, ea});
      end
      if (k == N + 3) chk({nm, "_we_hi"}, {31'd0, bus.mem_we}, 32'd1);
      if (k == N + 4) chk({nm, "_we_fall"}, {31'd0, bus.mem_we}, 32'd0);
      if (done) begin
        dcyc = k;
        break;
      end
      start = pulse && (k == 5 || k == N + 1);
    end
    start = 1'b0;
    chk({nm, "_done_cycle"}, dcyc, N + 5);
    chk({nm, "_writes"}, wr_cnt - base, 2);
  endtask

  task automatic check_result(input string nm, input logic [15:0] ra, input logic [7:0] en,
                              input logic [31:0] eh, input logic ef);
    logic [15:0] ra1;
    ra1 = ra + 16'd1;
    chk({nm, "_found"}, {31'd0, found}, {31'd0, ef});
    chk({nm, "_nonce"}, {24'd0, best_nonce}, {24'd0, en});
    chk({nm, "_hash"}, best_hash, eh);
    chk({nm, "_rec0"}, mem[ra], {ef, 23'd0, en});
    chk({nm, "_rec1"}, mem[ra1], eh);
  endtask

  initial begin
    int base;
    reset_n     = 1'b1;
    start       = 1'b0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    input_addr  = '0;
    result_addr = '0;
    target      = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr",  {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_wdata", bus.mem_write_data, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_nonce", {24'd0, best_nonce}, 32'd0);
    chk("rst_hash",  best_hash, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_done", {31'd0, done}, 32'd1);

    // Descending words 16..1, target 2: minimum at nonce 15, found.
    for (int i = 0; i < N; i++) ld(16'h0100 + 16'(i), 32'(16 - i));
    run_scan("desc", 16'h0100, 16'h0200, 32'd2, 1'b0);
    check_result("desc", 16'h0200, 8'd15, 32'd1, 1'b1);

    // Tie at nonces 5 and 9; target below the minimum -> not found, lower nonce kept.
    for (int i = 0; i < N; i++)
      ld(16'h0300 + 16'(i), (i == 5 || i == 9) ? 32'h0000_1234 : 32'hFFFF_0000);
    run_scan("tie", 16'h0300, 16'h0310, 32'h0000_1000, 1'b0);
    check_result("tie", 16'h0310, 8'd5, 32'h0000_1234, 1'b0);

    // All ones with an all-ones target: nothing is strictly smaller.
    for (int i = 0; i < N; i++) ld(16'h0400 + 16'(i), 32'hFFFF_FFFF);
    run_scan("ones", 16'h0400, 16'h0500, 32'hFFFF_FFFF, 1'b0);
    check_result("ones", 16'h0500, 8'd0, 32'hFFFF_FFFF, 1'b0);

    // Read addresses wrap past 0xFFFF; record's second word lands at 0x0000.
    for (int i = 0; i < N; i++) ld(16'hFFF8 + 16'(i), (i == 3) ? 32'd7 : 32'd50);
    run_scan("wrap", 16'hFFF8, 16'hFFFF, 32'd8, 1'b0);
    check_result("wrap", 16'hFFFF, 8'd3, 32'd7, 1'b1);

    // Asynchronous reset in the middle of READ.
    base        = wr_cnt;
    input_addr  = 16'h0100;
    result_addr = 16'h0700;
    target      = 32'd2;
    start       = 1'b1;
    @(posedge clk);                       // e0
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);            // e0+7
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("mid_rst_addr",  {16'd0, bus.mem_addr}, 32'd0);
    chk("mid_rst_done",  {31'd0, done}, 32'd0);
    chk("mid_rst_found", {31'd0, found}, 32'd0);
    chk("mid_rst_nonce", {24'd0, best_nonce}, 32'd0);
    chk("mid_rst_hash",  best_hash, 32'hFFFF_FFFF);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_done_rel", {31'd0, done}, 32'd1);
    chk("mid_rst_writes", wr_cnt - base, 0);
    run_scan("after_rst", 16'h0100, 16'h0700, 32'd2, 1'b0);
    check_result("after_rst", 16'h0700, 8'd15, 32'd1, 1'b1);

    // start re-pulsed during READ and WR0 must be ignored.
    run_scan("pulse", 16'h0100, 16'h0600, 32'd2, 1'b1);
    check_result("pulse", 16'h0600, 8'd15, 32'd1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
